send_frame: RTL and testbench

- Parametrised successor of the fixed three-byte PC response sender.
- On a level enable from the main FSM, snapshots an N-byte frame and streams it byte-by-byte to the UART transmitter with a proper EN_TX/BUSY_TX handshake.
- Optionally appends a checksum byte, and flags an error if the transmitter never acknowledges.
- Sits between the main control FSM and the UART transmitter.

---
 rtl/send_frame_if.sv | 38 +++
 rtl/send_frame.sv | 166 ++++++++++++++++
 tb/tb_send_frame.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/send_frame_if.sv
// Handshake bundle between the main control FSM, the frame sender and the
// UART transmitter. The slave modport is the frame sender's view.
interface send_frame_if #(
    parameter int NUM_BYTES = 3
);
    localparam int IDX_W = $clog2(NUM_BYTES + 2);

    logic                   EN;
    logic [8*NUM_BYTES-1:0] FRAME_DATA;
    logic                   BUSY_TX;
    logic                   EN_TX;
    logic [7:0]             RESPONSE_DATA;
    logic                   DONE;
    logic                   ERROR;
    logic [IDX_W-1:0]       BYTE_IDX;

    modport master (
        output EN,
        output FRAME_DATA,
        output BUSY_TX,
        input  EN_TX,
        input  RESPONSE_DATA,
        input  DONE,
        input  ERROR,
        input  BYTE_IDX
    );

    modport slave (
        input  EN,
        input  FRAME_DATA,
        input  BUSY_TX,
        output EN_TX,
        output RESPONSE_DATA,
        output DONE,
        output ERROR,
        output BYTE_IDX
    );
endinterface

// File: rtl/send_frame.sv
// Frame sender: snapshots an N-byte payload when enabled and streams it byte
// by byte to the UART transmitter using an EN_TX pulse / BUSY_TX handshake.
// An optional checksum byte (XOR or mod-256 sum) follows the payload, and a
// transmitter that never acknowledges a byte ends the frame with ERROR.
module send_frame #(
    parameter int NUM_BYTES   = 3,
    parameter int CHK_MODE    = 0,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    send_frame_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_BYTES + 2);
    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam int TOTAL = NUM_BYTES + ((CHK_MODE != 0) ? 1 : 0);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] PAYLOAD_N = IDX_W'(NUM_BYTES);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t                 state_r;
    logic [8*NUM_BYTES-1:0] shadow_r;
    logic [7:0]             acc_r;
    logic [TMR_W-1:0]       timer_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   en_tx_r;
    logic [7:0]             data_r;
    logic                   done_r;
    logic                   error_r;

    logic [7:0]             cur_byte_s;
    logic                   is_payload_s;
    logic [7:0]             tx_byte_s;

    // Fold one payload byte into the running checksum for the selected mode.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] res;
        case (CHK_MODE)
            1:       res = acc ^ b;
            2:       res = acc + b;
            default: res = acc;
        endcase
        return res;
    endfunction

    // Select the shadow byte addressed by the index, or the checksum once past the payload.
    always_comb begin
        cur_byte_s = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                cur_byte_s = shadow_r[8*i +: 8];
            end else begin
                cur_byte_s = cur_byte_s;
            end
        end
        is_payload_s = (idx_r < PAYLOAD_N);
        if (is_payload_s) begin
            tx_byte_s = cur_byte_s;
        end else begin
            tx_byte_s = acc_r;
        end
    end

    // Frame sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            shadow_r <= '0;
            acc_r    <= 8'h00;
            timer_r  <= '0;
            idx_r    <= '0;
            en_tx_r  <= 1'b0;
            data_r   <= 8'hFF;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            en_tx_r <= 1'b0;
            if ((state_r != S_IDLE) && !bus.EN) begin
                // Abort: drop back to IDLE, keep the last byte on the data lines.
                state_r <= S_IDLE;
                done_r  <= 1'b0;
                error_r <= 1'b0;
                idx_r   <= '0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        done_r  <= 1'b0;
                        error_r <= 1'b0;
                        if (bus.EN) begin
                            shadow_r <= bus.FRAME_DATA;
                            acc_r    <= 8'h00;
                            idx_r    <= '0;
                            state_r  <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (!bus.BUSY_TX) begin
                            data_r <= tx_byte_s;
                            if (is_payload_s) begin
                                acc_r <= chk_update(acc_r, cur_byte_s);
                            end
                            en_tx_r <= 1'b1;
                            timer_r <= '0;
                            state_r <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        // An acknowledge arriving on the expiry cycle still wins.
                        if (bus.BUSY_TX) begin
                            state_r <= S_WAIT_DONE;
                        end else if (timer_r == TMR_LAST) begin
                            state_r <= S_ERR;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else begin
                            timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!bus.BUSY_TX) begin
                            if (idx_r == LAST_IDX) begin
                                state_r <= S_FINISH;
                                done_r  <= 1'b1;
                                error_r <= 1'b0;
                            end else begin
                                idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                                state_r <= S_LOAD;
                            end
                        end
                    end
                    S_FINISH: begin
                        done_r  <= 1'b1;
                        error_r <= 1'b0;
                    end
                    S_ERR: begin
                        done_r  <= 1'b1;
                        error_r <= 1'b1;
                    end
                    default: begin
                        state_r <= S_IDLE;
                        done_r  <= 1'b0;
                        error_r <= 1'b0;
                        idx_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.EN_TX         = en_tx_r;
    assign bus.RESPONSE_DATA = data_r;
    assign bus.DONE          = done_r;
    assign bus.ERROR         = error_r;
    assign bus.BYTE_IDX      = idx_r;

endmodule

// File: tb/tb_send_frame.sv
// Directed bench for send_frame: three instances (no checksum with a short
// ack timeout, XOR checksum, sum checksum) each driven by a transmitter model.
// Expected bytes are queued when a frame is enabled and popped on EN_TX.
module tb_send_frame;
    logic clk;
    logic rst;

    send_frame_if #(.NUM_BYTES(3)) bus0 ();
    send_frame_if #(.NUM_BYTES(3)) bus1 ();
    send_frame_if #(.NUM_BYTES(3)) bus2 ();

    send_frame #(.NUM_BYTES(3), .CHK_MODE(0), .ACK_TIMEOUT(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    send_frame #(.NUM_BYTES(3), .CHK_MODE(1), .ACK_TIMEOUT(1024)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    send_frame #(.NUM_BYTES(3), .CHK_MODE(2), .ACK_TIMEOUT(1024)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt [3] = '{0, 0, 0};

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    logic [2:0] en_tx_v, done_v, error_v, busy_v;
    logic [7:0] data_v [3];
    logic [2:0] idx_v [3];

    // Transmitter model state
    logic [2:0] busy_r     = 3'b000;
    logic [2:0] ack_on     = 3'b111;
    logic [2:0] force_busy = 3'b000;
    int         left_r [3] = '{0, 0, 0};

    assign en_tx_v = {bus2.EN_TX, bus1.EN_TX, bus0.EN_TX};
    assign done_v  = {bus2.DONE, bus1.DONE, bus0.DONE};
    assign error_v = {bus2.ERROR, bus1.ERROR, bus0.ERROR};
    assign busy_v  = {bus2.BUSY_TX, bus1.BUSY_TX, bus0.BUSY_TX};
    assign data_v[0] = bus0.RESPONSE_DATA;
    assign data_v[1] = bus1.RESPONSE_DATA;
    assign data_v[2] = bus2.RESPONSE_DATA;
    assign idx_v[0]  = bus0.BYTE_IDX;
    assign idx_v[1]  = bus1.BYTE_IDX;
    assign idx_v[2]  = bus2.BYTE_IDX;

    assign bus0.BUSY_TX = busy_r[0] | force_busy[0];
    assign bus1.BUSY_TX = busy_r[1] | force_busy[1];
    assign bus2.BUSY_TX = busy_r[2] | force_busy[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the bytes a frame should produce: payload in order, then checksum.
    task automatic push_frame(input int ch, input logic [23:0] f, input int mode);
        logic [7:0] b, x, s;
        x = 8'h00;
        s = 8'h00;
        for (int i = 0; i < 3; i++) begin
            b = f[8*i +: 8];
            x = x ^ b;
            s = s + b;
            push_one(ch, {8'(i), b});
        end
        if (mode == 1) push_one(ch, {8'd3, x});
        if (mode == 2) push_one(ch, {8'd3, s});
    endtask

    task automatic push_one(input int ch, input logic [15:0] v);
        case (ch)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_one(input int ch, output logic [15:0] v, output bit ok);
        ok = 1'b1;
        v  = 16'h0000;
        case (ch)
            0: if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Transmitter model: busy rises the cycle after an EN_TX pulse and lasts 10 cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_r[i]) begin
                if (left_r[i] == 0) busy_r[i] <= 1'b0;
                else left_r[i] <= left_r[i] - 1;
            end else if (en_tx_v[i] && ack_on[i]) begin
                busy_r[i] <= 1'b1;
                left_r[i] <= 9;
            end
        end
    end

    // Scoreboard monitor: every EN_TX pulse must match the next expected {index, byte}.
    always @(negedge clk) begin
        logic [15:0] e;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            if (en_tx_v[i] === 1'b1) begin
                pulse_cnt[i]++;
                pop_one(i, e, ok);
                if (!ok) check($sformatf("ch%0d_unexpected_pulse", i), 32'd1, 32'd0);
                else check($sformatf("ch%0d_byte", i), {16'h0, 5'h0, idx_v[i], data_v[i]}, {16'h0, e});
            end
        end
    end

    task automatic wait_done(input logic [2:0] mask, input string tag);
        for (int k = 0; k < 400 && ((done_v & mask) != mask); k++) @(negedge clk);
        check(tag, {29'h0, done_v & mask}, {29'h0, mask});
    endtask

    initial begin
        int p;
        rst = 1'b1;
        bus0.EN = 1'b0; bus1.EN = 1'b0; bus2.EN = 1'b0;
        bus0.FRAME_DATA = 24'h3C12A5;
        bus1.FRAME_DATA = 24'h3C12A5;
        bus2.FRAME_DATA = 24'h3C12A5;
        repeat (2) @(negedge clk);
        check("rst_data", {24'h0, bus0.RESPONSE_DATA}, 32'hFF);
        check("rst_flags", {28'h0, bus0.EN_TX, bus0.DONE, bus0.ERROR, 1'b0}, 32'h0);
        check("rst_idx", {29'h0, bus0.BYTE_IDX}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Normal frames on all three checksum modes
        push_frame(0, 24'h3C12A5, 0);
        push_frame(1, 24'h3C12A5, 1);
        push_frame(2, 24'h3C12A5, 2);
        bus0.EN = 1'b1; bus1.EN = 1'b1; bus2.EN = 1'b1;
        @(negedge clk);
        check("lat_edge1", {31'h0, bus0.EN_TX}, 32'h0);
        @(negedge clk);
        check("lat_edge2", {31'h0, bus0.EN_TX}, 32'h1);
        wait_done(3'b111, "frame_done");
        repeat (20) @(negedge clk);
        check("frame_done_held", {29'h0, done_v}, 32'h7);
        check("frame_error", {29'h0, error_v}, 32'h0);
        check("pulses_ch0", pulse_cnt[0], 32'd3);
        check("pulses_ch1", pulse_cnt[1], 32'd4);
        check("pulses_ch2", pulse_cnt[2], 32'd4);
        check("queues_empty", qsize(0) + qsize(1) + qsize(2), 32'd0);
        bus0.EN = 1'b0; bus1.EN = 1'b0; bus2.EN = 1'b0;
        @(negedge clk);
        check("done_clear", {29'h0, done_v}, 32'h0);
        repeat (12) @(negedge clk);

        // Ack timeout on instance 0 (ACK_TIMEOUT=16)
        ack_on[0] = 1'b0;
        p = pulse_cnt[0];
        push_one(0, {8'd0, 8'hA5});
        bus0.EN = 1'b1;
        repeat (2) @(negedge clk);
        check("to_pulse", {31'h0, bus0.EN_TX}, 32'h1);
        repeat (15) @(negedge clk);
        check("to_not_yet", {30'h0, bus0.DONE, bus0.ERROR}, 32'h0);
        @(negedge clk);
        check("to_error", {30'h0, bus0.DONE, bus0.ERROR}, 32'h3);
        repeat (20) @(negedge clk);
        check("to_single_pulse", pulse_cnt[0] - p, 32'd1);
        check("to_held", {30'h0, bus0.DONE, bus0.ERROR}, 32'h3);
        bus0.EN = 1'b0;
        @(negedge clk);
        check("to_clear", {30'h0, bus0.DONE, bus0.ERROR}, 32'h0);
        ack_on[0] = 1'b1;

        // Busy at enable, then FRAME_DATA changed mid-frame
        force_busy[0] = 1'b1;
        p = pulse_cnt[0];
        push_frame(0, 24'h3C12A5, 0);
        bus0.EN = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_hold_nopulse", pulse_cnt[0] - p, 32'd0);
        bus0.FRAME_DATA = 24'hFFFFFF;
        force_busy[0] = 1'b0;
        wait_done(3'b001, "busy_frame_done");
        check("busy_frame_pulses", pulse_cnt[0] - p, 32'd3);
        check("busy_frame_q", qsize(0), 32'd0);
        bus0.EN = 1'b0;
        bus0.FRAME_DATA = 24'h3C12A5;
        repeat (15) @(negedge clk);

        // Abort during WAIT_DONE of byte 1, then restart
        p = pulse_cnt[0];
        push_one(0, {8'd0, 8'hA5});
        push_one(0, {8'd1, 8'h12});
        bus0.EN = 1'b1;
        for (int k = 0; k < 200 && !(bus0.BYTE_IDX == 3'd1 && bus0.BUSY_TX === 1'b1); k++) @(negedge clk);
        check("abort_reach", {31'h0, bus0.BUSY_TX}, 32'h1);
        @(negedge clk);
        bus0.EN = 1'b0;
        @(negedge clk);
        check("abort_state", {27'h0, bus0.BYTE_IDX, bus0.DONE, bus0.EN_TX}, 32'h0);
        repeat (30) @(negedge clk);
        check("abort_pulses", pulse_cnt[0] - p, 32'd2);
        p = pulse_cnt[0];
        push_frame(0, 24'h3C12A5, 0);
        bus0.EN = 1'b1;
        wait_done(3'b001, "restart_done");
        check("restart_pulses", pulse_cnt[0] - p, 32'd3);
        bus0.EN = 1'b0;
        repeat (15) @(negedge clk);

        // Asynchronous reset mid-frame
        p = pulse_cnt[0];
        push_one(0, {8'd0, 8'hA5});
        bus0.EN = 1'b1;
        for (int k = 0; k < 50 && pulse_cnt[0] == p; k++) @(negedge clk);
        check("rst_mid_pulse", pulse_cnt[0] - p, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_data", {24'h0, bus0.RESPONSE_DATA}, 32'hFF);
        check("arst_flags", {27'h0, bus0.BYTE_IDX, bus0.EN_TX, bus0.DONE}, 32'h0);
        bus0.EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("final_queues", qsize(0) + qsize(1) + qsize(2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
